pattern_edit_engine: RTL and testbench

//  Executes the cell-edit commands produced by the keyboard front end on the tracker's pattern RAM.

---
 rtl/pattern_edit_engine.sv | 165 ++++++++++++++++
 tb/tb_pattern_edit_engine.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pattern_edit_engine.sv
// pattern_edit_engine: one-shot read-modify-write of the pattern cell under the
// cursor, triggered by a key press and sharing the RAM port through req/gnt.
module pattern_edit_engine #(
    parameter int COLS    = 80,
    parameter int ROWS    = 30,
    parameter int DATA_W  = 8,
    parameter int ADDR_W  = 12,
    parameter int MAX_VAL = 255,
    parameter int RD_LAT  = 1
) (
    input  logic              clk,
    input  logic              Reset_n,
    input  logic [1:0]        user_edit,
    input  logic [6:0]        cursor_x,
    input  logic [6:0]        cursor_y,
    output logic              mem_req,
    input  logic              mem_gnt,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd_en,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              mem_wr_en,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              busy,
    output logic              done,
    output logic              err_range,
    output logic [DATA_W-1:0] last_val
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_REQ  = 3'd1;
    localparam logic [2:0] S_RD   = 3'd2;
    localparam logic [2:0] S_WAIT = 3'd3;
    localparam logic [2:0] S_MOD  = 3'd4;
    localparam logic [2:0] S_WR   = 3'd5;
    localparam logic [2:0] S_DONE = 3'd6;

    localparam logic [1:0] OP_INC = 2'b01;
    localparam logic [1:0] OP_DEC = 2'b10;
    localparam logic [1:0] OP_DEL = 2'b11;

    localparam logic [DATA_W-1:0] MAX_V    = DATA_W'(MAX_VAL);
    localparam logic [DATA_W-1:0] ONE_V    = DATA_W'(1);
    localparam logic [1:0]        LAT_LAST = 2'(RD_LAT - 1);

    logic [2:0]        state;
    logic [1:0]        edit_prev;
    logic              pending;
    logic [1:0]        op_q;
    logic [6:0]        x_q;
    logic [6:0]        y_q;
    logic [1:0]        cnt;
    logic [DATA_W-1:0] rdata_q;
    logic [DATA_W-1:0] new_val;
    logic [ADDR_W-1:0] addr_calc;
    logic              trigger;
    logic              in_range;

    assign trigger   = (user_edit != 2'b00) && (edit_prev == 2'b00) &&
                       (state == S_IDLE) && !pending;
    assign in_range  = (int'(x_q) < COLS) && (int'(y_q) < ROWS);
    assign addr_calc = ADDR_W'(y_q) * ADDR_W'(COLS) + ADDR_W'(x_q);

    // New cell value from the captured read data; increment never yields 0,
    // decrement of 0/1 or an out-of-range value wraps to the maximum.
    always_comb begin
        new_val = '0;
        if (op_q == OP_INC) begin
            if (rdata_q != '0 && rdata_q < MAX_V)
                new_val = rdata_q + ONE_V;
            else
                new_val = ONE_V;
        end else if (op_q == OP_DEC) begin
            if (rdata_q > ONE_V && (rdata_q < MAX_V || rdata_q == MAX_V))
                new_val = rdata_q - ONE_V;
            else
                new_val = MAX_V;
        end
    end

    // Strobes and status decoded straight from the state register.
    always_comb begin
        mem_req   = (state == S_REQ) || (state == S_RD) || (state == S_WAIT) ||
                    (state == S_MOD) || (state == S_WR);
        mem_rd_en = (state == S_RD);
        mem_wr_en = (state == S_WR);
        done      = (state == S_DONE);
        busy      = (state != S_IDLE);
    end

    // Edge detect, command latch, range check and the edit sequencer.
    // The trigger cycle only latches the command; the range check and address
    // multiply happen one cycle later while the FSM is still IDLE.
    always_ff @(posedge clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state     <= S_IDLE;
            edit_prev <= 2'b00;
            pending   <= 1'b0;
            op_q      <= 2'b00;
            x_q       <= '0;
            y_q       <= '0;
            cnt       <= '0;
            rdata_q   <= '0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            last_val  <= '0;
            err_range <= 1'b0;
        end else begin
            edit_prev <= user_edit;
            err_range <= 1'b0;

            if (trigger) begin
                pending <= 1'b1;
                op_q    <= user_edit;
                x_q     <= cursor_x;
                y_q     <= cursor_y;
            end

            case (state)
                S_IDLE: begin
                    if (pending) begin
                        pending <= 1'b0;
                        if (in_range) begin
                            mem_addr <= addr_calc;
                            state    <= S_REQ;
                        end else begin
                            err_range <= 1'b1;
                        end
                    end
                end
                S_REQ: begin
                    if (mem_gnt) begin
                        if (op_q == OP_DEL) begin
                            mem_wdata <= '0;
                            last_val  <= '0;
                            state     <= S_WR;
                        end else begin
                            state <= S_RD;
                        end
                    end
                end
                S_RD: begin
                    cnt   <= '0;
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    if (cnt == LAT_LAST) begin
                        rdata_q <= mem_rdata;
                        state   <= S_MOD;
                    end else begin
                        cnt <= cnt + 2'd1;
                    end
                end
                S_MOD: begin
                    mem_wdata <= new_val;
                    last_val  <= new_val;
                    state     <= S_WR;
                end
                S_WR:    state <= S_DONE;
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pattern_edit_engine.sv
// tb_pattern_edit_engine: directed steps against a behavioural pattern RAM with
// a write scoreboard (expected writes queued at stimulus, compared on output).
module tb_pattern_edit_engine;

    logic        clk = 1'b0;
    logic        Reset_n;
    logic [1:0]  user_edit;
    logic [6:0]  cursor_x;
    logic [6:0]  cursor_y;
    logic        mem_req;
    logic        mem_gnt;
    logic [11:0] mem_addr;
    logic        mem_rd_en;
    logic [7:0]  mem_rdata;
    logic        mem_wr_en;
    logic [7:0]  mem_wdata;
    logic        busy;
    logic        done;
    logic        err_range;
    logic [7:0]  last_val;

    pattern_edit_engine #(
        .COLS(80), .ROWS(30), .DATA_W(8), .ADDR_W(12), .MAX_VAL(255), .RD_LAT(1)
    ) dut (
        .clk(clk), .Reset_n(Reset_n), .user_edit(user_edit),
        .cursor_x(cursor_x), .cursor_y(cursor_y),
        .mem_req(mem_req), .mem_gnt(mem_gnt), .mem_addr(mem_addr),
        .mem_rd_en(mem_rd_en), .mem_rdata(mem_rdata),
        .mem_wr_en(mem_wr_en), .mem_wdata(mem_wdata),
        .busy(busy), .done(done), .err_range(err_range), .last_val(last_val)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [11:0] addr;
        logic [7:0]  data;
        int          rel;
    } exp_t;

    typedef struct {
        logic [11:0] addr;
        logic [7:0]  data;
        logic [7:0]  lv;
        int          cyc;
    } obs_t;

    exp_t sb[$];
    obs_t obs_q[$];

    logic [7:0]  ram [0:4095];
    logic        pl_req = 1'b0;
    logic [11:0] pl_addr = '0;
    logic [7:0]  pl_data = '0;

    int cyc = 0;
    int n_rd = 0, n_done = 0, n_err = 0, n_req = 0;
    int rd_cyc = 0, done_cyc = 0, err_cyc = 0;
    int n_cmp = 0, n_fail = 0;
    int t0 = 0;
    int b_rd, b_done, b_err, b_req;

    // Cycle counter: value k while between rising edges k and k+1.
    always @(posedge clk) cyc <= cyc + 1;

    // Pattern RAM with one-cycle read latency, plus bench preload port.
    always @(posedge clk) begin
        if (pl_req) ram[pl_addr] <= pl_data;
        if (mem_wr_en) ram[mem_addr] <= mem_wdata;
        if (mem_rd_en) mem_rdata <= ram[mem_addr];
    end

    // Output monitor, sampled mid-cycle.
    always @(negedge clk) begin
        if (mem_rd_en) begin n_rd <= n_rd + 1; rd_cyc <= cyc; end
        if (done) begin n_done <= n_done + 1; done_cyc <= cyc; end
        if (err_range) begin n_err <= n_err + 1; err_cyc <= cyc; end
        if (mem_req) n_req <= n_req + 1;
        if (mem_wr_en) obs_q.push_back('{mem_addr, mem_wdata, last_val, cyc});
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic poke(input int a, input int d);
        @(posedge clk); #1;
        pl_addr = 12'(a); pl_data = 8'(d); pl_req = 1'b1;
        @(posedge clk); #1;
        pl_req = 1'b0;
    endtask

    task automatic expect_wr(input int a, input int d, input int rel);
        sb.push_back('{12'(a), 8'(d), rel});
    endtask

    task automatic snap();
        b_rd = n_rd; b_done = n_done; b_err = n_err; b_req = n_req;
    endtask

    // Press a key after a rising edge; t0 marks the trigger edge.
    task automatic press(input logic [1:0] op, input int x, input int y, input int hold);
        @(posedge clk); #1;
        cursor_x = 7'(x); cursor_y = 7'(y); user_edit = op;
        t0 = cyc + 1;
        repeat (hold) @(posedge clk);
        #1 user_edit = 2'b00;
    endtask

    // Compare every observed write against the scoreboard.
    task automatic drain(input string tag, input int n_exp);
        obs_t o;
        exp_t e;
        check({tag, "_wr_count"}, obs_q.size(), n_exp);
        while (obs_q.size() > 0) begin
            o = obs_q.pop_front();
            if (sb.size() == 0) begin
                check({tag, "_unexpected_wr"}, {20'd0, o.addr}, 32'hFFFF_FFFF);
            end else begin
                e = sb.pop_front();
                check({tag, "_wr_addr"}, o.addr, e.addr);
                check({tag, "_wr_data"}, o.data, e.data);
                check({tag, "_last_val"}, o.lv, e.data);
                if (e.rel >= 0) check({tag, "_wr_cycle"}, o.cyc - t0, e.rel);
            end
        end
    endtask

    initial begin
        Reset_n = 1'b0; user_edit = 2'b00; cursor_x = '0; cursor_y = '0; mem_gnt = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_req", mem_req, 0);
        check("rst_rd", mem_rd_en, 0);
        check("rst_wr", mem_wr_en, 0);
        check("rst_addr", mem_addr, 0);
        check("rst_wdata", mem_wdata, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err", err_range, 0);
        check("rst_last", last_val, 0);
        @(negedge clk) Reset_n = 1'b1;

        // Increment held for 20 cycles: one write to 2*80+3.
        poke(163, 8'h05);
        expect_wr(163, 8'h06, 5);
        snap();
        press(2'b01, 3, 2, 20);
        repeat (5) @(posedge clk);
        check("inc_rd_count", n_rd - b_rd, 1);
        check("inc_rd_cycle", rd_cyc - t0, 2);
        check("inc_done_count", n_done - b_done, 1);
        check("inc_done_cycle", done_cyc - t0, 6);
        drain("inc", 1);
        check("inc_ram", ram[163], 8'h06);

        // Wrap cases.
        poke(10, 8'hFF); poke(11, 8'h01); poke(12, 8'h00);
        expect_wr(10, 8'h01, 5);
        press(2'b01, 10, 0, 3);
        repeat (10) @(posedge clk);
        drain("wrap_inc", 1);
        expect_wr(11, 8'hFF, 5);
        press(2'b10, 11, 0, 3);
        repeat (10) @(posedge clk);
        drain("wrap_dec1", 1);
        expect_wr(12, 8'hFF, 5);
        press(2'b10, 12, 0, 3);
        repeat (10) @(posedge clk);
        drain("wrap_dec0", 1);
        check("wrap_last", last_val, 8'hFF);

        // Delete at the far corner: no read, write at cycle 2, done at 3.
        poke(2399, 8'h40);
        expect_wr(2399, 8'h00, 2);
        snap();
        press(2'b11, 79, 29, 5);
        repeat (8) @(posedge clk);
        check("del_rd_count", n_rd - b_rd, 0);
        check("del_done_cycle", done_cyc - t0, 3);
        drain("del", 1);
        check("del_ram", ram[2399], 8'h00);
        check("del_last", last_val, 8'h00);

        // Arbitration: grant withheld for 7 cycles after the request.
        poke(85, 8'h10);
        expect_wr(85, 8'h11, -1);
        mem_gnt = 1'b0;
        snap();
        press(2'b01, 5, 1, 3);
        for (int k = 0; k < 10 && !mem_req; k++) @(negedge clk);
        check("arb_req", mem_req, 1);
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            check("arb_no_rd", mem_rd_en, 0);
            check("arb_addr", mem_addr, 85);
        end
        check("arb_rd_before_gnt", n_rd - b_rd, 0);
        mem_gnt = 1'b1;
        repeat (10) @(posedge clk);
        check("arb_rd_after_gnt", n_rd - b_rd, 1);
        drain("arb", 1);

        // Second press while busy is dropped, even when held past the end.
        poke(20, 8'h30); poke(21, 8'h07);
        expect_wr(20, 8'h31, 5);
        press(2'b01, 20, 0, 2);
        @(posedge clk); #1;
        cursor_x = 7'd21; user_edit = 2'b10;
        check("busy_mid_op", busy, 1);
        repeat (15) @(posedge clk);
        #1 user_edit = 2'b00;
        repeat (5) @(posedge clk);
        drain("busy_drop", 1);
        check("busy_drop_ram", ram[21], 8'h07);

        // Out-of-range cursor: error pulse, no request, no write.
        snap();
        press(2'b01, 80, 0, 3);
        repeat (6) @(posedge clk);
        check("range_x_err", n_err - b_err, 1);
        check("range_x_err_cycle", err_cyc - t0, 1);
        check("range_x_req", n_req - b_req, 0);
        snap();
        press(2'b10, 0, 30, 3);
        repeat (6) @(posedge clk);
        check("range_y_err", n_err - b_err, 1);
        check("range_y_req", n_req - b_req, 0);
        drain("range", 0);

        // Reset asserted during WAIT abandons the edit.
        poke(200, 8'h22);
        snap();
        @(posedge clk); #1;
        cursor_x = 7'd40; cursor_y = 7'd2; user_edit = 2'b01;
        t0 = cyc + 1;
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("mid_wait_rd", n_rd - b_rd, 1);
        check("mid_wait_busy", busy, 1);
        user_edit = 2'b00;
        Reset_n = 1'b0;
        #1;
        check("mid_rst_req", mem_req, 0);
        check("mid_rst_addr", mem_addr, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_wr", mem_wr_en, 0);
        check("mid_rst_last", last_val, 0);
        repeat (2) @(posedge clk);
        @(negedge clk) Reset_n = 1'b1;
        repeat (10) @(posedge clk);
        drain("mid_rst", 0);
        check("mid_rst_ram", ram[200], 8'h22);
        check("mid_rst_idle", busy, 0);
        check("sb_empty", sb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
